// File: rtl/quad_paddle_decoder.sv
// Quadrature A/B decoder: synchronised, glitch-filtered x4 decode driving a
// clamped paddle position with direction, step and illegal-transition reporting.
module quad_paddle_decoder #(
  parameter int unsigned POS_W       = 9,
  parameter int unsigned POS_MIN     = 0,
  parameter int unsigned POS_MAX     = 2**POS_W - 1,
  parameter int unsigned RESET_POS   = 0,
  parameter int unsigned STEP        = 1,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             quadA,
  input  logic             quadB,
  input  logic             enable,
  input  logic             zero,
  output logic [POS_W-1:0] position,
  output logic             dir,
  output logic             step_pulse,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic             at_min,
  output logic             at_max
);
  localparam int unsigned SETTLE = SYNC_STAGES + FILTER_LEN + 1;
  localparam int unsigned SET_W  = $clog2(SETTLE + 1);
  localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned PW1    = POS_W + 1;

  logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
  logic [1:0]             synced;
  logic [SET_W-1:0]       settle_q, settle_d;
  logic                   settling;
  logic [1:0]             filt_q, filt_d, prev_q, prev_d;
  logic [1:0][FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [1:0]             chg;
  logic                   valid_edge, illegal_edge, up;
  logic [PW1-1:0]         pos_ext, pos_sum, pos_floor;
  logic [POS_W-1:0]       pos_step;
  logic [POS_W-1:0]       pos_q, pos_d;
  logic                   dir_q, dir_d, step_q, step_d, err_q, err_d;
  logic [ERR_W-1:0]       errcnt_q, errcnt_d;

  // Channel index 0 is A, index 1 is B throughout.
  assign synced   = {sync_b_q[SYNC_STAGES-1], sync_a_q[SYNC_STAGES-1]};
  assign settling = (settle_q != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
      settle_q <= SET_W'(SETTLE);
      filt_q   <= '0;
      prev_q   <= '0;
      fcnt_q   <= '0;
      pos_q    <= POS_W'(RESET_POS);
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], quadA};
      sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], quadB};
      settle_q <= settle_d;
      filt_q   <= filt_d;
      prev_q   <= prev_d;
      fcnt_q   <= fcnt_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  // While settling, filtered and previous levels both track the synced pair so
  // the first decoded cycle starts from a consistent baseline.
  always_comb begin
    settle_d = settling ? settle_q - SET_W'(1) : settle_q;
    filt_d   = filt_q;
    fcnt_d   = fcnt_q;
    prev_d   = settling ? synced : filt_q;
    for (int i = 0; i < 2; i++) begin
      if (settling) begin
        filt_d[i] = synced[i];
        fcnt_d[i] = '0;
      end else if (synced[i] == filt_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_q[i] == FCNT_W'(FILTER_LEN - 1)) begin
        filt_d[i] = synced[i];
        fcnt_d[i] = '0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + FCNT_W'(1);
      end
    end
  end

  // Decode and clamped position update; arithmetic carries one extra bit.
  always_comb begin
    chg          = prev_q ^ filt_q;
    valid_edge   = !settling && (chg[0] ^ chg[1]);
    illegal_edge = !settling && (&chg);
    up           = prev_q[0] ^ filt_q[1];
    pos_ext      = {1'b0, pos_q};
    pos_sum      = pos_ext + PW1'(STEP);
    pos_floor    = PW1'(POS_MIN) + PW1'(STEP);
    if (up) begin
      pos_step = (pos_sum > PW1'(POS_MAX)) ? POS_W'(POS_MAX) : pos_sum[POS_W-1:0];
    end else begin
      pos_step = (pos_ext < pos_floor) ? POS_W'(POS_MIN) : POS_W'(pos_ext - PW1'(STEP));
    end

    pos_d    = pos_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    err_d    = 1'b0;
    errcnt_d = errcnt_q;
    if (valid_edge) begin
      dir_d = up;
      if (enable) begin
        pos_d  = pos_step;
        step_d = 1'b1;
      end
    end
    if (illegal_edge) begin
      err_d = 1'b1;
      if (errcnt_q != '1) errcnt_d = errcnt_q + ERR_W'(1);
    end
    if (zero) begin
      pos_d  = POS_W'(RESET_POS);
      step_d = 1'b0;
    end
  end

  assign position   = pos_q;
  assign dir        = dir_q;
  assign step_pulse = step_q;
  assign err        = err_q;
  assign err_count  = errcnt_q;
  assign at_min     = (pos_q == POS_W'(POS_MIN));
  assign at_max     = (pos_q == POS_W'(POS_MAX));

endmodule
